// File: rtl/bram_fwft_fifo_if.sv
// Valid/ready bundle for the block-RAM backed FWFT FIFO.
// The slave side is the FIFO; the master side is the producer/consumer.
interface bram_fwft_fifo_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [ADDR_WIDTH+1:0] level;

  modport slave (
    input  wr_valid, data_in, rd_ready,
    output wr_ready, rd_valid, rd_data, level
  );

  modport master (
    output wr_valid, data_in, rd_ready,
    input  wr_ready, rd_valid, rd_data, level
  );
endinterface

// File: rtl/bram_fwft_fifo.sv
// Synchronous FIFO over a registered-read dual-port RAM, drained
// into a 2-entry head/skid buffer to give a FWFT stream.
module bram_fwft_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9
) (
  input  logic            clk,
  input  logic            rst,
  bram_fwft_fifo_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LW    = ADDR_WIDTH + 2;
  localparam logic [ADDR_WIDTH:0] FULL =
    {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE = 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_skid;
  logic [ADDR_WIDTH:0]   r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic [ADDR_WIDTH:0]   w_fill;
  logic                  r_inflight;
  logic [1:0]            r_buf_count;
  logic [1:0]            w_left;
  logic [2:0]            w_occ;
  logic                  w_wr_ready;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_issue;
  logic                  w_rd_valid;

  assign w_fill     = r_wr_ptr - r_rd_ptr;
  assign w_wr_ready = !rst && (w_fill != FULL);
  assign w_push     = bus.wr_valid && w_wr_ready;
  assign w_rd_valid = (r_buf_count != 2'd0);
  assign w_pop      = w_rd_valid && bus.rd_ready;
  assign w_left     = r_buf_count - {1'b0, w_pop};
  assign w_occ      = 3'(w_left) + 3'(r_inflight);
  assign w_issue    = (w_fill != '0) && (w_occ < 3'd2);

  assign bus.wr_ready = w_wr_ready;
  assign bus.rd_valid = w_rd_valid;
  assign bus.rd_data  = r_head;
  assign bus.level    = LW'(w_fill) + LW'(r_inflight)
                      + LW'(r_buf_count);

  // Write and read addresses never coincide, so RAM read mode is moot
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= bus.data_in;
    if (w_issue)
      r_rdata <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_inflight  <= 1'b0;
      r_buf_count <= 2'd0;
      r_head      <= '0;
      r_skid      <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + ONE;
      if (w_issue)
        r_rd_ptr <= r_rd_ptr + ONE;
      r_inflight  <= w_issue;
      r_buf_count <= w_occ[1:0];
      // Arriving word lands in head only if nothing older remains
      if (r_inflight && w_left == 2'd0)
        r_head <= r_rdata;
      else if (w_pop && r_buf_count == 2'd2)
        r_head <= r_skid;
      if (r_inflight && w_left != 2'd0)
        r_skid <= r_rdata;
    end
  end
endmodule

// File: tb/tb_bram_fwft_fifo.sv
// Directed and scoreboard bench for bram_fwft_fifo at ADDR_WIDTH=4.
// Vector table covers reset and latency; sequences cover the rest.
module tb_bram_fwft_fifo;
  localparam int DW = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  bram_fwft_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  bram_fwft_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst;
    logic        wv;
    logic [15:0] din;
    logic        rr;
    logic        e_wrr;
    logic        e_rv;
    logic        c_rd;
    logic [15:0] e_rd;
    logic [5:0]  e_lvl;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] sb [$];
    int sent, got, acc, exp_w, pushed, popped;

    bus.wr_valid = 1'b0;
    bus.data_in  = '0;
    bus.rd_ready = 1'b0;

    //          rst   wv    din       rr    wrr   rv    crd   rd        lvl
    tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 6'd0};
    tbl[1]  = '{1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 6'd0};
    tbl[2]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 6'd0};
    tbl[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 6'd0};
    tbl[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 6'd0};
    tbl[5]  = '{1'b0, 1'b1, 16'hA5A5, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 6'd1};
    tbl[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 6'd1};
    tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'hA5A5, 6'd1};
    tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'hA5A5, 6'd1};
    tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 6'd0};
    tbl[10] = '{1'b0, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 6'd1};
    tbl[11] = '{1'b0, 1'b1, 16'h0002, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 6'd2};
    tbl[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0001, 6'd2};
    tbl[13] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0002, 6'd1};
    tbl[14] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 6'd0};

    for (int i = 0; i < 15; i++) begin
      rst          = tbl[i].rst;
      bus.wr_valid = tbl[i].wv;
      bus.data_in  = tbl[i].din;
      bus.rd_ready = tbl[i].rr;
      tick();
      chk($sformatf("v%0d_wr_ready", i), bus.wr_ready, tbl[i].e_wrr);
      chk($sformatf("v%0d_rd_valid", i), bus.rd_valid, tbl[i].e_rv);
      chk($sformatf("v%0d_level", i), bus.level, tbl[i].e_lvl);
      if (tbl[i].c_rd)
        chk($sformatf("v%0d_rd_data", i), bus.rd_data, tbl[i].e_rd);
    end

    // Streaming: 0..99 with the consumer always ready
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b1;
    sent = 0;
    got  = 0;
    for (int c = 0; c < 400 && got < 100; c++) begin
      bus.wr_valid = (sent < 100);
      bus.data_in  = 16'(sent);
      if (bus.rd_valid) begin
        chk("stream_data", bus.rd_data, got);
        got++;
      end else if (got > 0) begin
        chk("stream_gap", bus.rd_valid, 1'b1);
      end
      if (bus.wr_valid && bus.wr_ready)
        sent++;
      tick();
    end
    bus.wr_valid = 1'b0;
    chk("stream_count", got, 100);
    tick();
    chk("stream_empty", bus.level, 0);

    // Fill to full with the consumer stalled
    bus.rd_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 30; c++) begin
      bus.wr_valid = 1'b1;
      bus.data_in  = 16'(acc);
      if (bus.wr_ready)
        acc++;
      tick();
      if (bus.rd_valid)
        chk("full_hold", bus.rd_data, 0);
    end
    bus.wr_valid = 1'b0;
    chk("full_accepted", acc, 18);
    chk("full_wr_ready", bus.wr_ready, 1'b0);
    chk("full_level", bus.level, 18);
    chk("full_rd_valid", bus.rd_valid, 1'b1);

    bus.rd_ready = 1'b1;
    exp_w = 0;
    for (int c = 0; c < 80 && exp_w < 18; c++) begin
      if (bus.rd_valid) begin
        chk("drain_data", bus.rd_data, exp_w);
        exp_w++;
      end
      tick();
    end
    chk("drain_count", exp_w, 18);
    chk("drain_level", bus.level, 0);
    chk("drain_rd_valid", bus.rd_valid, 1'b0);

    // Random backpressure against a queue scoreboard
    pushed = 0;
    popped = 0;
    for (int c = 0; c < 60000 && popped < 10000; c++) begin
      bus.wr_valid = (pushed < 10000) ? 1'($urandom_range(1)) : 1'b0;
      bus.rd_ready = 1'($urandom_range(1));
      bus.data_in  = 16'($urandom);
      chk("rand_level", bus.level, sb.size());
      if (sb.size() < 16)
        chk("rand_wr_ready_hi", bus.wr_ready, 1'b1);
      if (sb.size() == 18)
        chk("rand_wr_ready_lo", bus.wr_ready, 1'b0);
      if (sb.size() == 0)
        chk("rand_rd_valid_lo", bus.rd_valid, 1'b0);
      if (bus.rd_valid && bus.rd_ready && sb.size() > 0) begin
        chk("rand_data", bus.rd_data, sb[0]);
        void'(sb.pop_front());
        popped++;
      end
      if (bus.wr_valid && bus.wr_ready) begin
        sb.push_back(bus.data_in);
        pushed++;
      end
      tick();
    end
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    chk("rand_popped", popped, 10000);
    tick();

    // Reset mid-stream with seven words held
    for (int i = 0; i < 7; i++) begin
      bus.wr_valid = 1'b1;
      bus.data_in  = 16'(16'h0100 + i);
      tick();
    end
    bus.wr_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_level", bus.level, 7);
    rst = 1'b1;
    tick();
    chk("mid_rst_level", bus.level, 0);
    chk("mid_rst_rd_valid", bus.rd_valid, 1'b0);
    chk("mid_rst_wr_ready", bus.wr_ready, 1'b0);
    rst          = 1'b0;
    bus.wr_valid = 1'b1;
    bus.data_in  = 16'h1234;
    tick();
    bus.wr_valid = 1'b0;
    chk("mid_e0_wr_ready", bus.wr_ready, 1'b1);
    chk("mid_e0_rd_valid", bus.rd_valid, 1'b0);
    chk("mid_e0_level", bus.level, 1);
    tick();
    chk("mid_e1_rd_valid", bus.rd_valid, 1'b0);
    tick();
    chk("mid_e2_rd_valid", bus.rd_valid, 1'b1);
    chk("mid_e2_rd_data", bus.rd_data, 16'h1234);
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mid_no_stale", bus.rd_valid, 1'b0);
    end
    chk("mid_final_level", bus.level, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
